// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the ALU and its command queue.
//   ALU_OP_W      opcode width
//   ALU_OP_*      opcode values understood by the ALU
//   alu_cmd_t     command record {opcode, in0, in1} at the default ALU width
//   alu_cmd_w()   packed command width for an arbitrary operand width
package alu_pkg;

  localparam int ALU_OP_W          = 3;
  localparam int ALU_WIDTH_DEFAULT = 16;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHL  = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHR  = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_PASS = 3'd7;

  typedef struct packed {
    logic [ALU_OP_W-1:0]          opcode;
    logic [ALU_WIDTH_DEFAULT-1:0] in0;
    logic [ALU_WIDTH_DEFAULT-1:0] in1;
  } alu_cmd_t;

  function automatic int alu_cmd_w(input int width);
    return ALU_OP_W + 2 * width;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: single-clock FIFO with registered pointers carrying an extra
// wrap bit; read data is the current head (no output register, no bypass).
// Pushes while full and pops while empty are ignored.
//   clk, rst_n       clock, asynchronous active-low reset (pointers only)
//   i_push, i_wdata  write request and data
//   i_pop            read request (advances head)
//   o_rdata          head entry
//   o_full, o_empty  status
//   o_level          occupancy 0..DEPTH
module alu_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      i_push,
  input  logic [W-1:0]                              i_wdata,
  input  logic                                      i_pop,
  output logic [W-1:0]                              o_rdata,
  output logic                                      o_full,
  output logic                                      o_empty,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0] o_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // Wrap the index at DEPTH and toggle the lap bit, so non-power-of-2
  // depths still work.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
    return p + LW'(1);
  endfunction

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    o_level = '0;
    if (r_wptr[AW] == r_rptr[AW]) o_level = LW'(r_wptr[AW-1:0]) - LW'(r_rptr[AW-1:0]);
    else                          o_level = LW'(DEPTH) - LW'(r_rptr[AW-1:0]) + LW'(r_wptr[AW-1:0]);
  end

  // Control: pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
    end
  end

  // Data: storage, not reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: issue stage in front of the ALU.
// Commands {opcode,in0,in1} are buffered in a FIFO and issued one per cycle to
// registered alu_* outputs while a response credit is available. A shift
// register tracks each issued command through the ALU latency and writes
// {overflow,out} into a response FIFO, which is returned in order on rsp_*.
// Credits equal the response FIFO depth, so a result always has room.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_opcode, cmd_in0, cmd_in1        command fields
//   alu_opcode, alu_in0, alu_in1        registered ALU operands
//   alu_out, alu_overflow               ALU result
//   rsp_valid/rsp_ready                 response handshake
//   rsp_data, rsp_overflow              head response
//   cmd_level                           command FIFO occupancy
// Build option ALU_CMDQ_OVF_STICKY_EN adds ovf_clr (in) / ovf_sticky (out):
// sticky flag set by any overflow result written to the response FIFO.
import alu_pkg::*;

module alu_cmd_queue #(
  parameter int WIDTH     = 16,
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ALU_OP_W-1:0]          cmd_opcode,
  input  logic [WIDTH-1:0]             cmd_in0,
  input  logic [WIDTH-1:0]             cmd_in1,
  output logic [ALU_OP_W-1:0]          alu_opcode,
  output logic [WIDTH-1:0]             alu_in0,
  output logic [WIDTH-1:0]             alu_in1,
  input  logic [WIDTH-1:0]             alu_out,
  input  logic                         alu_overflow,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         rsp_overflow,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level
`ifdef ALU_CMDQ_OVF_STICKY_EN
  ,
  input  logic                         ovf_clr,
  output logic                         ovf_sticky
`endif
);

  localparam int CMD_W  = alu_cmd_w(WIDTH);
  localparam int RSP_W  = WIDTH + 1;
  localparam int CRD_W  = $clog2(RSP_DEPTH + 1);
  localparam int RLVL_W = $clog2(RSP_DEPTH) + 1;

  logic              w_cmd_push;
  logic              w_cmd_full;
  logic              w_cmd_empty;
  logic [CMD_W-1:0]  w_cmd_wdata;
  logic [CMD_W-1:0]  w_cmd_head;
  logic              w_issue;
  logic              w_rsp_push;
  logic              w_rsp_pop;
  logic              w_rsp_full;
  logic              w_rsp_empty;
  logic [RSP_W-1:0]  w_rsp_head;
  logic [RLVL_W-1:0] w_rsp_level;
  logic [CRD_W-1:0]  r_credit;
  logic [ALU_LAT:0]  r_inflight;

  assign cmd_ready   = !w_cmd_full;
  assign w_cmd_push  = cmd_valid && !w_cmd_full;
  assign w_cmd_wdata = {cmd_opcode, cmd_in0, cmd_in1};
  assign w_issue     = !w_cmd_empty && (r_credit != '0);
  // Bit ALU_LAT marks the cycle in which alu_out belongs to a tracked command.
  assign w_rsp_push  = r_inflight[ALU_LAT];
  assign w_rsp_pop   = !w_rsp_empty && rsp_ready;
  assign rsp_valid   = !w_rsp_empty;
  assign {rsp_overflow, rsp_data} = w_rsp_head;

  alu_sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cmd_push),
    .i_wdata (w_cmd_wdata),
    .i_pop   (w_issue),
    .o_rdata (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_level (cmd_level)
  );

  alu_sync_fifo #(.W(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rsp_push),
    .i_wdata ({alu_overflow, alu_out}),
    .i_pop   (w_rsp_pop),
    .o_rdata (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_level (w_rsp_level)
  );

  // Issue stage: operand registers, credit counter, in-flight tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit   <= CRD_W'(RSP_DEPTH);
      r_inflight <= '0;
      alu_opcode <= '0;
      alu_in0    <= '0;
      alu_in1    <= '0;
    end else begin
      r_inflight <= {r_inflight[ALU_LAT-1:0], w_issue};
      case ({w_issue, w_rsp_pop})
        2'b10:   r_credit <= r_credit - CRD_W'(1);
        2'b01:   r_credit <= r_credit + CRD_W'(1);
        default: r_credit <= r_credit;
      endcase
      if (w_issue) {alu_opcode, alu_in0, alu_in1} <= w_cmd_head;
    end
  end

`ifdef ALU_CMDQ_OVF_STICKY_EN
  logic r_ovf_sticky;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_ovf_sticky <= 1'b0;
    else if (w_rsp_push && alu_overflow)  r_ovf_sticky <= 1'b1;
    else if (ovf_clr)                     r_ovf_sticky <= 1'b0;
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

  // Outstanding results (in flight plus buffered) never exceed the credits.
  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp_push && w_rsp_full));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(r_credit) + int'(w_rsp_level)) <= RSP_DEPTH);

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Testbench for alu_cmd_queue: a behavioural ALU stub closes the loop, and a
// queue-based reference model predicts every output each cycle.
import alu_pkg::*;

module tb_alu_cmd_queue;

  localparam int WIDTH     = 16;
  localparam int CMD_DEPTH = 8;
  localparam int RSP_DEPTH = 4;
  localparam int ALU_LAT   = 1;
  localparam int N_RAND    = 10000;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [15:0] cmd_in0, cmd_in1;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_in0, alu_in1, alu_out;
  logic        alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_overflow;
  logic [15:0] rsp_data;
  logic [3:0]  cmd_level;
`ifdef ALU_CMDQ_OVF_STICKY_EN
  logic        ovf_clr = 1'b0;
  logic        ovf_sticky;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_queue #(.WIDTH(WIDTH), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_in0      (cmd_in0),
    .cmd_in1      (cmd_in1),
    .alu_opcode   (alu_opcode),
    .alu_in0      (alu_in0),
    .alu_in1      (alu_in1),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .cmd_level    (cmd_level)
`ifdef ALU_CMDQ_OVF_STICKY_EN
    ,
    .ovf_clr      (ovf_clr),
    .ovf_sticky   (ovf_sticky)
`endif
  );

  // Reference ALU behaviour: {overflow, out}
  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      ALU_OP_ADD:  return {1'b0, a} + {1'b0, b};
      ALU_OP_SUB:  return {(a < b), 16'(a - b)};
      ALU_OP_AND:  return {1'b0, a & b};
      ALU_OP_OR:   return {1'b0, a | b};
      ALU_OP_XOR:  return {1'b0, a ^ b};
      ALU_OP_SHL:  return {1'b0, a << b[3:0]};
      ALU_OP_SHR:  return {1'b0, a >> b[3:0]};
      default:     return {1'b0, a};
    endcase
  endfunction

  // ALU stub with ALU_LAT register stages
  logic [16:0] alu_pipe [ALU_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] <= '0;
    end else begin
      alu_pipe[0] <= alu_fn(alu_opcode, alu_in0, alu_in1);
      for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
  end
  assign alu_out      = alu_pipe[ALU_LAT-1][15:0];
  assign alu_overflow = alu_pipe[ALU_LAT-1][16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queued commands, results in flight with edge countdowns,
  // buffered responses, credit count, and the last issued command.
  cmd_t        m_cmdq[$];
  logic [16:0] m_rspq[$];
  logic [16:0] m_fl_res[$];
  int          m_fl_cnt[$];
  int          m_credit = RSP_DEPTH;
  cmd_t        m_alu = '0;
  int          m_accepted = 0;
  int          m_popped = 0;
  bit          m_acc, m_iss, m_pop;
  cmd_t        m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmdq.delete(); m_rspq.delete(); m_fl_res.delete(); m_fl_cnt.delete();
      m_credit = RSP_DEPTH;
      m_alu = '0;
    end else begin
      m_acc = cmd_valid && (m_cmdq.size() < CMD_DEPTH);
      m_iss = (m_cmdq.size() > 0) && (m_credit > 0);
      m_pop = (m_rspq.size() > 0) && rsp_ready;
      if (m_pop) begin
        void'(m_rspq.pop_front());
        m_credit++;
        m_popped++;
      end
      foreach (m_fl_cnt[i]) m_fl_cnt[i]--;
      while (m_fl_cnt.size() > 0 && m_fl_cnt[0] == 0) begin
        m_rspq.push_back(m_fl_res.pop_front());
        void'(m_fl_cnt.pop_front());
      end
      if (m_iss) begin
        m_c = m_cmdq.pop_front();
        m_alu = m_c;
        m_fl_res.push_back(alu_fn(m_c.op, m_c.a, m_c.b));
        m_fl_cnt.push_back(ALU_LAT + 1);
        m_credit--;
      end
      if (m_acc) begin
        m_cmdq.push_back('{cmd_opcode, cmd_in0, cmd_in1});
        m_accepted++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, m_cmdq.size() < CMD_DEPTH);
    chk("cmd_level", cmd_level, m_cmdq.size());
    chk("rsp_valid", rsp_valid, m_rspq.size() > 0);
    chk("alu_opcode", alu_opcode, m_alu.op);
    chk("alu_in0", alu_in0, m_alu.a);
    chk("alu_in1", alu_in1, m_alu.b);
    if (m_rspq.size() > 0) begin
      chk("rsp_data", rsp_data, m_rspq[0][15:0]);
      chk("rsp_overflow", rsp_overflow, m_rspq[0][16]);
    end
  end

  // Offer one command from a negedge; returns at the negedge after the handshake.
  task automatic push_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_in0 = a; cmd_in1 = b;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL push_timeout actual=cmd_ready_low required=accept_within_100");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic single_latency(input string tag);
    int hs, n;
    rsp_ready = 1'b1;
    push_cmd(ALU_OP_ADD, 16'd20, 16'd4);
    hs = cyc;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, cyc - hs, ALU_LAT + 2);
    chk({tag, "_data"}, rsp_data, 24);
    chk({tag, "_ovf"}, rsp_overflow, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, first, last, p0, base, pbase, budget;
    cmd_valid = 0; cmd_opcode = 0; cmd_in0 = 0; cmd_in1 = 0; rsp_ready = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_level", cmd_level, 0);
    chk("rst_alu_in0", alu_in0, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Pin the reference ALU with hand-computed values
    chk("model_add", alu_fn(ALU_OP_ADD, 16'd20, 16'd4), 17'h00018);
    chk("model_add_ovf", alu_fn(ALU_OP_ADD, 16'hFFFF, 16'h0001), 17'h10000);
    chk("model_sub_borrow", alu_fn(ALU_OP_SUB, 16'd3, 16'd5), 17'h1FFFE);

    // Test 1: single command latency
    single_latency("t1");

    // Test 2: back-to-back opcodes 0..7
    rsp_ready = 1'b1;
    s = 0; first = 0; last = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) push_cmd(i[2:0], 16'd20, 16'd4);
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (rsp_valid) begin
            if (s == 0) first = t;
            last = t;
            s++;
          end
        end
      end
    join
    chk("t2_rsp_count", s, 8);
    chk("t2_consecutive", last - first, 7);

    // Test 3: blocked consumer fills both FIFOs, then drains
    rsp_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_cmd(3'($urandom_range(7)), 16'($urandom), 16'($urandom));
    repeat (3) @(negedge clk);
    chk("t3_cmd_level", cmd_level, 8);
    chk("t3_cmd_ready", cmd_ready, 0);
    chk("t3_rsp_valid", rsp_valid, 1);
    p0 = m_popped;
    rsp_ready = 1'b1;
    n = 0;
    while (m_popped - p0 < 12 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t3_drained", m_popped - p0, 12);
    chk("t3_empty_level", cmd_level, 0);

    // Test 4: add overflow
    push_cmd(ALU_OP_ADD, 16'hFFFF, 16'h0001);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ovf", rsp_overflow, 1);
    chk("t4_data", rsp_data, 0);
`ifdef ALU_CMDQ_OVF_STICKY_EN
    @(negedge clk);
    chk("t4_sticky_held", ovf_sticky, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("t4_sticky_cleared", ovf_sticky, 0);
    push_cmd(ALU_OP_ADD, 16'hFFFF, 16'h0002);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_set_wins", ovf_sticky, 1);
    @(negedge clk);
    chk("t4_sticky_after_clr", ovf_sticky, 0);
    ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Test 5: reset with queued and buffered work
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_cmd(ALU_OP_XOR, 16'($urandom), 16'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_cmd_ready", cmd_ready, 1);
    chk("t5_rst_cmd_level", cmd_level, 0);
    chk("t5_rst_alu_opcode", alu_opcode, 0);
    chk("t5_rst_alu_in0", alu_in0, 0);
    chk("t5_rst_alu_in1", alu_in1, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_stale", rsp_valid, 0);
    end
    single_latency("t5");

    // Test 6: random traffic
    base = m_accepted; pbase = m_popped; budget = 0;
    while (m_accepted - base < N_RAND && budget < 60000) begin
      cmd_valid  = ($urandom_range(3) != 0);
      cmd_opcode = 3'($urandom_range(7));
      cmd_in0    = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      cmd_in1    = 16'($urandom);
      rsp_ready  = ($urandom_range(2) != 0);
      @(negedge clk);
      budget++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("t6_accepted", (m_accepted - base) >= N_RAND, 1);
    n = 0;
    while ((m_popped - pbase) != (m_accepted - base) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_all_returned", m_popped - pbase, m_accepted - base);
    @(negedge clk);
    chk("t6_final_rsp_valid", rsp_valid, 0);
    chk("t6_final_level", cmd_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
